// File: rtl/jtag_regbank_pkg.sv
// Shared frame layout constants and helpers for the JTAG register bank.
package jtag_regbank_pkg;

  // Position of the write flag (scan-in) / error flag (capture) in a frame.
  localparam int WR_BIT   = 0;
  // First bit of the address field; data follows the address.
  localparam int ADDR_LSB = 1;

  // Total frame length: flag bit, address field, data field.
  function automatic int frame_len(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/jtag_sync.sv
// Multi-flop synchroniser for one asynchronous JTAG input bit.
module jtag_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_reg;

  // Shift the raw bit through the chain; the last stage is the safe copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_reg[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_regbank.sv
// Addressed bank of JTAG-accessible control registers and status inputs.
// The UJTAG user-DR signals are oversampled on clk, so no DRCK domain exists.
module jtag_regbank
  import jtag_regbank_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int NUM_REGS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           jtag_sel,
  input  logic                           jtag_tck,
  input  logic                           jtag_tdi,
  input  logic                           jtag_tlr,
  input  logic                           jtag_cdr,
  input  logic                           jtag_sdr,
  input  logic                           jtag_udr,
  output logic                           jtag_tdo,
  output logic [NUM_REGS*DATA_WIDTH-1:0] control,
  output logic [NUM_REGS-1:0]            ctrl_wr_stb,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status,
  output logic                           rd_stb,
  output logic [ADDR_WIDTH-1:0]          rd_addr
);

  localparam int FRAME_LEN = frame_len(ADDR_WIDTH, DATA_WIDTH);
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]      CNT_SAT    = CNT_W'(FRAME_LEN + 1);
  localparam logic [ADDR_WIDTH:0]   NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

  // Synchronised JTAG inputs.
  logic [6:0] raw_in;
  logic [6:0] sync_q;
  logic       sel_s, tck_s, tdi_s, tlr_s, cdr_s, sdr_s, udr_s;

  assign raw_in = {jtag_sel, jtag_tck, jtag_tdi, jtag_tlr, jtag_cdr, jtag_sdr, jtag_udr};

  for (genvar gi = 0; gi < 7; gi++) begin : g_sync
    jtag_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (raw_in[gi]),
      .q  (sync_q[gi])
    );
  end

  assign {sel_s, tck_s, tdi_s, tlr_s, cdr_s, sdr_s, udr_s} = sync_q;

  // Scan state.
  logic                  tck_prev_reg;
  logic                  udr_prev_reg;
  logic [FRAME_LEN-1:0]  shift_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [ADDR_WIDTH-1:0] last_addr_reg;
  logic                  err_reg;
  logic                  rd_stb_reg;
  logic [ADDR_WIDTH-1:0] rd_addr_reg;
  logic                  tdo_reg;

  logic                  tck_rise;
  logic                  udr_rise;
  logic                  frm_wr;
  logic [ADDR_WIDTH-1:0] frm_addr;
  logic [DATA_WIDTH-1:0] frm_data;
  logic                  frm_addr_ok;
  logic                  len_ok;
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] status_word;

  // Edges only count while the user IR is selected.
  assign tck_rise    = tck_s & ~tck_prev_reg & sel_s;
  assign udr_rise    = udr_s & ~udr_prev_reg & sel_s;

  assign frm_wr      = shift_reg[WR_BIT];
  assign frm_addr    = shift_reg[ADDR_LSB +: ADDR_WIDTH];
  assign frm_data    = shift_reg[FRAME_LEN-1 -: DATA_WIDTH];
  assign frm_addr_ok = {1'b0, frm_addr} < NUM_REGS_W;
  assign len_ok      = (cnt_reg == CNT_FULL);
  // A write lands only for a full-length frame aimed at an implemented register.
  assign wr_commit   = udr_rise & ~tlr_s & len_ok & frm_wr & frm_addr_ok;

  // Select the status word for the previously addressed register, 0 if unimplemented.
  always_comb begin
    status_word = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (last_addr_reg == ADDR_WIDTH'(r)) begin
        status_word = status[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Track previous synced TCK and UDR levels for rise detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_prev_reg <= 1'b0;
      udr_prev_reg <= 1'b0;
    end else begin
      tck_prev_reg <= tck_s;
      udr_prev_reg <= udr_s;
    end
  end

  // Capture, shift and update handling of the scan chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg     <= '0;
      cnt_reg       <= '0;
      last_addr_reg <= '0;
      err_reg       <= 1'b0;
      rd_stb_reg    <= 1'b0;
      rd_addr_reg   <= '0;
    end else begin
      rd_stb_reg <= 1'b0;
      if (tlr_s) begin
        shift_reg     <= '0;
        cnt_reg       <= '0;
        last_addr_reg <= '0;
        err_reg       <= 1'b0;
      end else if (tck_rise && cdr_s) begin
        shift_reg   <= {status_word, last_addr_reg, err_reg};
        cnt_reg     <= '0;
        rd_stb_reg  <= 1'b1;
        rd_addr_reg <= last_addr_reg;
      end else if (tck_rise && sdr_s) begin
        shift_reg <= {tdi_s, shift_reg[FRAME_LEN-1:1]};
        if (cnt_reg != CNT_SAT) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end else if (udr_rise) begin
        if (!len_ok) begin
          err_reg <= 1'b1;
        end else begin
          last_addr_reg <= frm_addr;
          err_reg       <= ~frm_addr_ok;
        end
      end
    end
  end

  // TDO follows the chain LSB one cycle later; it holds with the chain when deselected.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdo_reg <= 1'b0;
    end else begin
      tdo_reg <= shift_reg[0];
    end
  end

  // One control register and write strobe per implemented address.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_ctrl
    logic [DATA_WIDTH-1:0] ctrl_reg;
    logic                  stb_reg;

    // Load the register and pulse its strobe when a valid write targets it.
    always_ff @(posedge clk) begin
      if (rst) begin
        ctrl_reg <= '0;
        stb_reg  <= 1'b0;
      end else begin
        stb_reg <= wr_commit && (frm_addr == ADDR_WIDTH'(gi));
        if (wr_commit && (frm_addr == ADDR_WIDTH'(gi))) begin
          ctrl_reg <= frm_data;
        end
      end
    end

    assign control[gi*DATA_WIDTH +: DATA_WIDTH] = ctrl_reg;
    assign ctrl_wr_stb[gi]                      = stb_reg;
  end

  assign jtag_tdo = tdo_reg;
  assign rd_stb   = rd_stb_reg;
  assign rd_addr  = rd_addr_reg;

endmodule

// File: tb/tb_jtag_regbank.sv
// Bench for jtag_regbank: table-driven scans, hand-written corner sequences,
// then random scans checked against a frame-level model.
module tb_jtag_regbank;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 4;
  localparam int L  = 1 + AW + DW;

  logic             clk = 1'b0;
  logic             rst;
  logic             jtag_sel, jtag_tck, jtag_tdi, jtag_tlr, jtag_cdr, jtag_sdr, jtag_udr;
  logic             jtag_tdo;
  logic [NR*DW-1:0] control;
  logic [NR-1:0]    ctrl_wr_stb;
  logic [NR*DW-1:0] status;
  logic             rd_stb;
  logic [AW-1:0]    rd_addr;

  logic [DW-1:0]    sxor [NR];

  int errors = 0;
  int checks = 0;

  // Frame-level model state.
  logic [DW-1:0]    m_ctrl [NR];
  logic [AW-1:0]    m_last;
  logic             m_err;

  // Strobe monitor state (written only by the monitor).
  int               wr_pulses = 0;
  int               rd_pulses = 0;
  int               viol = 0;
  logic [NR-1:0]    last_wr_val = '0;
  logic [AW-1:0]    last_rd_addr = '0;
  logic             prev_wr = 1'b0;
  logic             prev_rd = 1'b0;

  always #5 clk = ~clk;

  jtag_regbank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .jtag_sel(jtag_sel), .jtag_tck(jtag_tck), .jtag_tdi(jtag_tdi),
    .jtag_tlr(jtag_tlr), .jtag_cdr(jtag_cdr), .jtag_sdr(jtag_sdr), .jtag_udr(jtag_udr),
    .jtag_tdo(jtag_tdo), .control(control), .ctrl_wr_stb(ctrl_wr_stb),
    .status(status), .rd_stb(rd_stb), .rd_addr(rd_addr)
  );

  // Status loops back from control, perturbed by a bench-chosen XOR per register.
  for (genvar gi = 0; gi < NR; gi++) begin : g_status
    assign status[gi*DW +: DW] = control[gi*DW +: DW] ^ sxor[gi];
  end

  // Count strobe pulses and flag multi-cycle, overlapping or multi-hot strobes.
  always @(negedge clk) begin
    if (ctrl_wr_stb != '0) begin
      wr_pulses++;
      last_wr_val = ctrl_wr_stb;
      if (prev_wr || rd_stb || $countones(ctrl_wr_stb) != 1) viol++;
    end
    if (rd_stb) begin
      rd_pulses++;
      last_rd_addr = rd_addr;
      if (prev_rd) viol++;
    end
    prev_wr = (ctrl_wr_stb != '0);
    prev_rd = rd_stb;
  end

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // One TCK period at f_clk/10: sample TDO before the rise and before the fall.
  task automatic tck_cycle(output logic pre_rise, output logic pre_fall);
    tick(5);
    pre_rise = jtag_tdo;
    jtag_tck = 1'b1;
    tick(5);
    pre_fall = jtag_tdo;
    jtag_tck = 1'b0;
  endtask

  function automatic logic [63:0] model_cap();
    logic [63:0] c;
    c = '0;
    c[0]    = m_err;
    c[AW:1] = m_last;
    if (m_last < NR) c[L-1:AW+1] = m_ctrl[m_last] ^ sxor[m_last];
    return c;
  endfunction

  // Full scan: Capture-DR, n shift cycles, Update-DR; checks TDO stream, strobes and control.
  task automatic do_scan(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int n, input logic use_tbl, input logic [NR-1:0] tbl_stb,
                         output logic [63:0] cap_out);
    logic [63:0] c, tv, e, rb, fb, msk;
    logic [NR-1:0] exp_stb, seen_stb;
    logic [AW-1:0] exp_rd;
    logic pr, pf;
    int wr0, rd0;
    c  = model_cap();
    tv = {$urandom, $urandom};
    tv[L-1:0] = {data, addr, wr};
    e = '0;
    for (int i = 0; i <= n; i++) e[i] = (i < L) ? c[i] : tv[i-L];
    rb = '0;
    fb = '0;
    exp_rd = m_last;
    wr0 = wr_pulses;
    rd0 = rd_pulses;
    jtag_cdr = 1'b1;
    tck_cycle(pr, pf);
    fb[0] = pf;
    jtag_cdr = 1'b0;
    jtag_sdr = 1'b1;
    for (int i = 0; i < n; i++) begin
      jtag_tdi = tv[i];
      tck_cycle(pr, pf);
      rb[i]   = pr;
      fb[i+1] = pf;
    end
    jtag_sdr = 1'b0;
    jtag_tdi = 1'b0;
    tick(5);
    jtag_udr = 1'b1;
    tick(5);
    jtag_udr = 1'b0;
    tick(8);

    exp_stb  = (n == L && wr && addr < NR) ? NR'(1 << addr) : '0;
    seen_stb = (wr_pulses != wr0) ? last_wr_val : '0;
    msk = (64'd1 << n) - 64'd1;
    chk("tdo_before_rise", rb & msk, e & msk);
    msk = (64'd1 << (n + 1)) - 64'd1;
    chk("tdo_before_fall", fb & msk, e & msk);
    chk("rd_stb_count", 64'(rd_pulses - rd0), 64'd1);
    chk("rd_addr", 64'(last_rd_addr), 64'(exp_rd));
    chk("wr_stb_count", 64'(wr_pulses - wr0), (exp_stb != '0) ? 64'd1 : 64'd0);
    chk("wr_stb_value", 64'(seen_stb), 64'(exp_stb));
    if (use_tbl) chk("tbl_wr_stb", 64'(seen_stb), 64'(tbl_stb));

    if (n != L) begin
      m_err = 1'b1;
    end else begin
      m_last = addr;
      m_err  = (addr >= NR);
      if (wr && addr < NR) m_ctrl[addr] = data;
    end
    for (int r = 0; r < NR; r++) chk($sformatf("control[%0d]", r), 64'(control[r*DW +: DW]), 64'(m_ctrl[r]));
    cap_out = rb;
    $display("scan wr=%0b addr=%0d data=0x%08h bits=%0d captured=0x%010h strobe=%b", wr, addr, data, n, rb & ((64'd1 << L) - 64'd1), seen_stb);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            nbits;
    logic [DW-1:0] sx1;
    logic [NR-1:0] exp_stb;
    logic          exp_err;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [63:0] cap;
    logic pr, pf;
    int nb;
    logic [AW-1:0] ra;

    tbl[0] = '{1'b1, 4'd2, 32'hDEADBEEF, 37, 32'h0,        4'b0100, 1'b0};
    tbl[1] = '{1'b0, 4'd1, 32'h0,        37, 32'h12345678, 4'b0000, 1'b0};
    tbl[2] = '{1'b1, 4'd7, 32'h55AA55AA, 37, 32'h12345678, 4'b0000, 1'b1};
    tbl[3] = '{1'b1, 4'd1, 32'h11111111, 36, 32'h12345678, 4'b0000, 1'b1};
    tbl[4] = '{1'b1, 4'd1, 32'h22222222, 40, 32'h12345678, 4'b0000, 1'b1};
    tbl[5] = '{1'b1, 4'd0, 32'hCAFEF00D, 37, 32'h12345678, 4'b0001, 1'b0};
    tbl[6] = '{1'b1, 4'd3, 32'h000000A5, 37, 32'h12345678, 4'b1000, 1'b0};

    for (int r = 0; r < NR; r++) begin
      sxor[r]   = '0;
      m_ctrl[r] = '0;
    end
    m_last = '0;
    m_err  = 1'b0;
    rst = 1'b1;
    jtag_sel = 1'b1;
    {jtag_tck, jtag_tdi, jtag_tlr, jtag_cdr, jtag_sdr, jtag_udr} = '0;
    tick(4);
    chk("reset_control", 64'(control != '0), 64'd0);
    chk("reset_wr_stb", 64'(ctrl_wr_stb), 64'd0);
    chk("reset_rd_stb", 64'(rd_stb), 64'd0);
    chk("reset_rd_addr", 64'(rd_addr), 64'd0);
    chk("reset_tdo", 64'(jtag_tdo), 64'd0);
    rst = 1'b0;
    tick(4);

    // Table-driven scans; each capture reports the error flag of the previous entry.
    for (int i = 0; i < 7; i++) begin
      sxor[1] = tbl[i].sx1;
      do_scan(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].nbits, 1'b1, tbl[i].exp_stb, cap);
      if (i == 1) chk("cap_after_deadbeef", cap[L-1:0], {32'hDEADBEEF, 4'd2, 1'b0});
      if (i == 2) chk("cap_after_read1", cap[L-1:0], {32'h12345678, 4'd1, 1'b0});
      if (i == 3) chk("cap_after_bad_addr", cap[L-1:0], {32'h0, 4'd7, 1'b1});
      if (i > 0) chk("tbl_err", 64'(cap[0]), 64'(tbl[i-1].exp_err));
    end
    sxor[1] = '0;
    do_scan(1'b0, 4'd3, 32'h0, L, 1'b0, '0, cap);
    chk("tbl_err", 64'(cap[0]), 64'(tbl[6].exp_err));
    chk("readback_a5", 64'(cap[L-1:AW+1]), 64'h0A5);

    // Test-Logic-Reset clears scan state but keeps control.
    jtag_tlr = 1'b1;
    tick(5);
    jtag_tlr = 1'b0;
    tick(5);
    m_last = '0;
    m_err  = 1'b0;
    chk("tlr_keeps_ctrl3", 64'(control[3*DW +: DW]), 64'h0A5);
    do_scan(1'b0, 4'd2, 32'h0, L, 1'b0, '0, cap);
    chk("tlr_cap_addr", 64'(cap[AW:1]), 64'd0);
    chk("tlr_cap_err", 64'(cap[0]), 64'd0);

    // Reset in the middle of a shift, then an Update-DR with no capture.
    jtag_cdr = 1'b1;
    tck_cycle(pr, pf);
    jtag_cdr = 1'b0;
    jtag_sdr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      jtag_tdi = 1'($urandom);
      tck_cycle(pr, pf);
    end
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_control", 64'(control != '0), 64'd0);
    chk("midrst_wr_stb", 64'(ctrl_wr_stb), 64'd0);
    chk("midrst_rd_stb", 64'(rd_stb), 64'd0);
    chk("midrst_rd_addr", 64'(rd_addr), 64'd0);
    chk("midrst_tdo", 64'(jtag_tdo), 64'd0);
    $display("reset asserted mid-shift");
    for (int r = 0; r < NR; r++) m_ctrl[r] = '0;
    m_last = '0;
    jtag_sdr = 1'b0;
    jtag_tdi = 1'b0;
    tick(5);
    jtag_udr = 1'b1;
    tick(5);
    jtag_udr = 1'b0;
    tick(8);
    m_err = 1'b1;
    do_scan(1'b1, 4'd1, 32'h0BADF00D, L, 1'b0, '0, cap);
    chk("udr_no_capture_err", 64'(cap[0]), 64'd1);

    // Random scans against the model.
    for (int k = 0; k < 30; k++) begin
      for (int r = 0; r < NR; r++) sxor[r] = $urandom;
      case ($urandom_range(0, 9))
        0:       nb = 36;
        1:       nb = 38;
        2:       nb = $urandom_range(1, 12);
        default: nb = L;
      endcase
      ra = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, NR - 1));
      do_scan(1'($urandom), ra, $urandom, nb, 1'b0, '0, cap);
      if ($urandom_range(0, 7) == 0) begin
        jtag_tlr = 1'b1;
        tick(5);
        jtag_tlr = 1'b0;
        tick(5);
        m_last = '0;
        m_err  = 1'b0;
        $display("tlr pulse");
      end
    end

    chk("strobe_shape", 64'(viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
